// File: rtl/adc_spi_pkg.sv
// ---------------------------------------------------------------------------
// adc_spi_pkg
//   Shared constants for the ADC SPI link: FSM state encodings, config word
//   bit positions, reset config and the data/config widths that the SPI
//   master also uses.
// ---------------------------------------------------------------------------
package adc_spi_pkg;

    localparam int DATA_BITS = 12;
    localparam int CFG_BITS  = 6;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CONVERT  = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;
    localparam logic [1:0] ST_SHIFT    = 2'd3;

    // Config word {S/D, O/S, S1, S0, UNI, SLP}
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    // ch0, single-ended, unipolar
    localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 6'b100010;

    function automatic logic [2:0] cfg_channel(input logic [CFG_BITS-1:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Brings an asynchronous input into the clk domain through STAGES flops
//   (STAGES >= 2) and produces single-cycle rise/fall pulses.
//   clk, reset_n : clock, async active-low reset
//   din          : asynchronous input
//   level        : synchronized level
//   rise, fall   : 1-cycle pulses on synchronized transitions
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], din};
            level_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------
// adc_spi_responder
//   ADC-side end of the CONVST/SCK/SDI/SDO link. Emulates a 12-bit 8-channel
//   converter: CONVST captures sample_data, a fixed conversion time runs,
//   then a 12-clock frame shifts the result out on spi_sdo (MSB first, on SCK
//   fall) while the next config word shifts in on spi_sdi (on SCK rise).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for CONVST rise
//   CONVERT  | conversion timer running, busy high
//   WAIT_LOW | conversion done, waiting for CONVST low to present MSB
//   SHIFT    | frame in progress
//
//   Ports: clk, reset_n; CONVST/spi_scl/spi_sdi async from the master;
//   spi_sdo result bit; sample_req/sample_ch/sample_data fabric sample
//   handshake; cfg_out active config; busy; frame_done/frame_abort pulses.
// ---------------------------------------------------------------------------
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 CONVST,
    input  logic                 spi_scl,
    input  logic                 spi_sdi,
    output logic                 spi_sdo,
    output logic                 sample_req,
    output logic [2:0]           sample_ch,
    input  logic [DATA_BITS-1:0] sample_data,
    output logic [CFG_BITS-1:0]  cfg_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int CNT_W = $clog2(CONV_CYCLES);
    localparam logic [DATA_BITS-1:0] BIPOLAR_FLIP = {1'b1, {(DATA_BITS-1){1'b0}}};

    logic cv_level, cv_rise, cv_fall_unused;
    logic sck_level_unused, sck_rise, sck_fall;
    logic sdi_level, sdi_rise_unused, sdi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cv (
        .clk(clk), .reset_n(reset_n), .din(CONVST),
        .level(cv_level), .rise(cv_rise), .fall(cv_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .din(spi_scl),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    // SDI goes through the same depth as SCK so its level lines up with sck_rise.
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset_n(reset_n), .din(spi_sdi),
        .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    logic [1:0]           state;
    logic [CNT_W-1:0]     conv_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] data_sr;
    logic [CFG_BITS-1:0]  cfg_sr;
    logic                 start_conv;

    // A CONVST rise mid-frame aborts the frame and restarts like IDLE; it also
    // takes priority over any SCK edge seen in the same cycle.
    assign start_conv = cv_rise && (state == ST_IDLE || state == ST_SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            conv_cnt    <= '0;
            bit_cnt     <= '0;
            data_sr     <= '0;
            cfg_sr      <= '0;
            cfg_out     <= CFG_DEFAULT;
            sample_ch   <= '0;
            spi_sdo     <= 1'b0;
            sample_req  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            sample_req  <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (start_conv) begin
                frame_abort <= (state == ST_SHIFT);
                sample_req  <= 1'b1;
                data_sr     <= cfg_out[CFG_UNI] ? sample_data : (sample_data ^ BIPOLAR_FLIP);
                sample_ch   <= cfg_channel(cfg_out);
                conv_cnt    <= CNT_W'(CONV_CYCLES - 1);
                busy        <= 1'b1;
                spi_sdo     <= 1'b0;
                bit_cnt     <= '0;
                cfg_sr      <= '0;
                state       <= ST_CONVERT;
            end else begin
                case (state)
                    ST_CONVERT: begin
                        if (conv_cnt == '0) begin
                            busy  <= 1'b0;
                            state <= ST_WAIT_LOW;
                        end else begin
                            conv_cnt <= conv_cnt - 1'b1;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (!cv_level) begin
                            spi_sdo <= data_sr[DATA_BITS-1];
                            data_sr <= data_sr << 1;
                            bit_cnt <= '0;
                            state   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (sck_rise) begin
                            if (bit_cnt < 4'(CFG_BITS))
                                cfg_sr <= {cfg_sr[CFG_BITS-2:0], sdi_level};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (sck_fall && bit_cnt != '0) begin
                            // bit_cnt counts rises, so this fall ends bit (bit_cnt-1)
                            if (bit_cnt == 4'(DATA_BITS)) begin
                                frame_done <= 1'b1;
                                cfg_out    <= cfg_sr;
                                spi_sdo    <= 1'b0;
                                state      <= ST_IDLE;
                            end else begin
                                spi_sdo <= data_sr[DATA_BITS-1];
                                data_sr <= data_sr << 1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        convst = 1'b0;
    logic        spi_scl = 1'b0;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo;
    logic        sample_req;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data = 12'h000;
    logic [5:0]  cfg_out;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;

    int tests = 0;
    int fails = 0;
    int n_req = 0, n_done = 0, n_abort = 0, n_busy = 0;

    always #5 clk = ~clk;

    adc_spi_responder dut (
        .clk(clk), .reset_n(reset_n), .CONVST(convst), .spi_scl(spi_scl),
        .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .sample_req(sample_req),
        .sample_ch(sample_ch), .sample_data(sample_data), .cfg_out(cfg_out),
        .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always @(negedge clk) begin
        if (sample_req)  n_req++;
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (busy)        n_busy++;
    end

    function automatic logic [5:0] mk_cfg(input logic [2:0] c);
        // c = {S1,S0,O/S}; single-ended, unipolar, SLP=0
        return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
    endfunction

    task automatic wait_busy_low();
        int cyc = 0;
        while (busy !== 1'b0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic start_conv(input logic [11:0] d);
        sample_data = d;
        convst = 1'b1;
        repeat (6) @(negedge clk);
        convst = 1'b0;
        wait_busy_low();
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input logic [5:0] cfg_word, input int nbits, output logic [11:0] word);
        word = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = (i < 6) ? cfg_word[5-i] : 1'b0;
            repeat (6) @(negedge clk);
            word[11-i] = spi_sdo;
            spi_scl = 1'b1;
            repeat (6) @(negedge clk);
            spi_scl = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({spi_sdo, sample_req, busy, frame_done, frame_abort} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outs: got %b, required 00000",
                     {spi_sdo, sample_req, busy, frame_done, frame_abort});
        end
        tests++;
        if (cfg_out !== 6'b100010 || sample_ch !== 3'd0) begin
            fails++;
            $display("FAIL reset_cfg: cfg=%b ch=%0d, required 100010 / 0", cfg_out, sample_ch);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int r0, d0, b0;
        logic [11:0] w;
        r0 = n_req; d0 = n_done; b0 = n_busy;
        start_conv(12'hA5C);
        tests++;
        if (n_req - r0 != 1) begin
            fails++; $display("FAIL basic_sample_req: got %0d pulses, required 1", n_req - r0);
        end
        tests++;
        if (n_busy - b0 != 80) begin
            fails++; $display("FAIL basic_busy_len: got %0d cycles, required 80", n_busy - b0);
        end
        tests++;
        if (sample_ch !== 3'd0) begin
            fails++; $display("FAIL basic_ch: got %0d, required 0", sample_ch);
        end
        run_frame(6'b110010, 12, w);
        tests++;
        if (w !== 12'hA5C) begin
            fails++; $display("FAIL basic_sdo: got %h, required a5c", w);
        end
        tests++;
        if (n_done - d0 != 1) begin
            fails++; $display("FAIL basic_frame_done: got %0d pulses, required 1", n_done - d0);
        end
        tests++;
        if (cfg_out !== 6'b110010) begin
            fails++; $display("FAIL basic_cfg: got %b, required 110010", cfg_out);
        end
    endtask

    // Each frame shifts in the config for the next channel; the following
    // conversion must report that channel.
    task automatic test_channels();
        logic [2:0]  exp_ch;
        logic [11:0] d, w;
        exp_ch = 3'd1;  // from cfg 110010
        for (int c = 0; c < 9; c++) begin
            d = 12'h100 + 12'(c * 12'h137);
            start_conv(d);
            tests++;
            if (sample_ch !== exp_ch) begin
                fails++; $display("FAIL chan_%0d: sample_ch=%0d, required %0d", c, sample_ch, exp_ch);
            end
            run_frame((c < 8) ? mk_cfg(3'(c)) : 6'b100000, 12, w);
            tests++;
            if (w !== d) begin
                fails++; $display("FAIL chan_sdo_%0d: got %h, required %h", c, w, d);
            end
            exp_ch = 3'(c);
        end
        tests++;
        if (cfg_out !== 6'b100000) begin
            fails++; $display("FAIL chan_final_cfg: got %b, required 100000", cfg_out);
        end
    endtask

    task automatic test_bipolar();
        logic [11:0] w;
        start_conv(12'h000);
        run_frame(6'b100000, 12, w);
        tests++;
        if (w !== 12'h800) begin
            fails++; $display("FAIL bipolar_zero: got %h, required 800", w);
        end
        start_conv(12'hFFF);
        run_frame(6'b100000, 12, w);
        tests++;
        if (w !== 12'h7FF) begin
            fails++; $display("FAIL bipolar_full: got %h, required 7ff", w);
        end
    endtask

    task automatic test_abort();
        int r0, d0, a0;
        logic [11:0] w;
        start_conv(12'h123);
        run_frame(6'b111111, 5, w);
        r0 = n_req; d0 = n_done; a0 = n_abort;
        sample_data = 12'h456;
        convst = 1'b1;
        repeat (6) @(negedge clk);
        convst = 1'b0;
        tests++;
        if (n_abort - a0 != 1) begin
            fails++; $display("FAIL abort_pulse: got %0d pulses, required 1", n_abort - a0);
        end
        tests++;
        if (n_req - r0 != 1) begin
            fails++; $display("FAIL abort_new_req: got %0d pulses, required 1", n_req - r0);
        end
        tests++;
        if (cfg_out !== 6'b100000 || n_done != d0) begin
            fails++; $display("FAIL abort_cfg: cfg=%b done=%0d, required 100000 / 0", cfg_out, n_done - d0);
        end
        wait_busy_low();
        repeat (4) @(negedge clk);
        run_frame(6'b100000, 12, w);
        tests++;
        if (w !== 12'hC56) begin
            fails++; $display("FAIL abort_next_sdo: got %h, required c56", w);
        end
    endtask

    task automatic test_early_low();
        int k;
        logic [11:0] w;
        // CONVST already low when the conversion ends
        sample_data = 12'h123;  // bipolar -> 923, MSB 1
        convst = 1'b1;
        repeat (6) @(negedge clk);
        convst = 1'b0;
        wait_busy_low();
        k = 0;
        while (spi_sdo !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k < 1 || k > 2) begin
            fails++; $display("FAIL early_low_latency: got %0d clk, required 1..2", k);
        end
        repeat (4) @(negedge clk);
        run_frame(6'b100000, 12, w);
        tests++;
        if (w !== 12'h923) begin
            fails++; $display("FAIL early_low_sdo: got %h, required 923", w);
        end
        // CONVST held high past the end of conversion: MSB waits for it
        convst = 1'b1;
        repeat (6) @(negedge clk);
        wait_busy_low();
        repeat (20) @(negedge clk);
        tests++;
        if (spi_sdo !== 1'b0) begin
            fails++; $display("FAIL held_high_sdo: got %b, required 0", spi_sdo);
        end
        convst = 1'b0;
        k = 0;
        while (spi_sdo !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k < 2 || k > 4) begin
            fails++; $display("FAIL held_high_latency: got %0d clk, required 2..4", k);
        end
        repeat (4) @(negedge clk);
        run_frame(6'b100000, 12, w);
    endtask

    task automatic test_reset_mid_frame();
        int d0, bad;
        logic [11:0] w;
        start_conv(12'h123);     // result 923
        run_frame(6'b010101, 3, w);
        tests++;
        if (spi_sdo !== 1'b1) begin
            fails++; $display("FAIL mid_frame_sdo: got %b, required 1", spi_sdo);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (spi_sdo !== 1'b0 || cfg_out !== 6'b100010 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: sdo=%b cfg=%b busy=%b, required 0 100010 0", spi_sdo, cfg_out, busy);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        d0 = n_done;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            spi_sdi = 1'b1;
            repeat (6) @(negedge clk);
            if (spi_sdo !== 1'b0) bad++;
            spi_scl = 1'b1;
            repeat (6) @(negedge clk);
            if (spi_sdo !== 1'b0) bad++;
            spi_scl = 1'b0;
        end
        repeat (8) @(negedge clk);
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL idle_sck_sdo: %0d samples nonzero, required 0", bad);
        end
        tests++;
        if (n_done != d0 || cfg_out !== 6'b100010) begin
            fails++;
            $display("FAIL idle_sck_state: done=%0d cfg=%b, required 0 / 100010", n_done - d0, cfg_out);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_channels();
        test_bipolar();
        test_abort();
        test_early_low();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
